// File: rtl/reg_write_sequencer.sv
// Register-write sequencer: buffers destination masks in a small FIFO and
// serialises each set bit into an op/out transaction on the decoder select bus.
// Optional macro WSEQ_STAT_CNT_EN adds a saturating wr_count of out phases.
module reg_write_sequencer #(
  parameter int FIFO_DEPTH = 4,
  parameter int MASK_W     = 10
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req_valid,
  input  logic [MASK_W-1:0] req_mask,
  output logic              req_ready,
  output logic [3:0]        sel,
  output logic              en_op,
  output logic              en_out,
  output logic              busy,
  output logic              mask_done,
`ifdef WSEQ_STAT_CNT_EN
  output logic              err_zero,
  output logic [15:0]       wr_count
`else
  output logic              err_zero
`endif
);

  localparam int AW = $clog2(FIFO_DEPTH);

  typedef enum logic [1:0] {IDLE, OP, OUT} state_t;

  // Mask bit index to decoder select code; unused codes never come out.
  function automatic logic [3:0] code_of(input logic [3:0] idx);
    case (idx)
      4'd0:    code_of = 4'b0001;
      4'd1:    code_of = 4'b0100;
      4'd2:    code_of = 4'b0101;
      4'd3:    code_of = 4'b0110;
      4'd4:    code_of = 4'b0111;
      4'd5:    code_of = 4'b1000;
      4'd6:    code_of = 4'b1001;
      4'd7:    code_of = 4'b1010;
      4'd8:    code_of = 4'b1011;
      4'd9:    code_of = 4'b1100;
      default: code_of = 4'b0000;
    endcase
  endfunction

  // Index of the lowest set bit (scan high to low, last hit wins).
  function automatic logic [3:0] low_idx(input logic [MASK_W-1:0] m);
    logic [3:0] r;
    r = '0;
    for (int i = MASK_W - 1; i >= 0; i--)
      if (m[i]) r = 4'(i);
    return r;
  endfunction

  state_t                             state_q, state_d;
  logic [FIFO_DEPTH-1:0][MASK_W-1:0]  fifo_q, fifo_d;
  logic [AW-1:0]                      wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [AW:0]                        cnt_q, cnt_d;
  logic [MASK_W-1:0]                  work_q, work_d;
  logic [3:0]                         sel_q, sel_d;
  logic                               en_op_q, en_op_d, en_out_q, en_out_d;
  logic                               mask_done_q, mask_done_d, err_zero_q, err_zero_d;
  logic                               accept, push, pop;

  // FIFO bookkeeping; a zero mask is acknowledged but never stored.
  always_comb begin
    req_ready  = (cnt_q != (AW + 1)'(FIFO_DEPTH));
    accept     = req_valid && req_ready;
    push       = accept && (|req_mask);
    pop        = (state_q == IDLE) && (cnt_q != '0);
    err_zero_d = accept && !(|req_mask);
    fifo_d     = fifo_q;
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    cnt_d      = cnt_q;
    if (push) begin
      fifo_d[wr_ptr_q] = req_mask;
      wr_ptr_d         = wr_ptr_q + AW'(1);
    end
    if (pop) rd_ptr_d = rd_ptr_q + AW'(1);
    case ({push, pop})
      2'b10:   cnt_d = cnt_q + (AW + 1)'(1);
      2'b01:   cnt_d = cnt_q - (AW + 1)'(1);
      default: cnt_d = cnt_q;
    endcase
    busy = (cnt_q != '0) || (state_q != IDLE);
  end

  // Next state; bus outputs are registered so they trail the state by a cycle.
  always_comb begin
    state_d     = state_q;
    work_d      = work_q;
    sel_d       = sel_q;
    en_op_d     = 1'b0;
    en_out_d    = 1'b0;
    mask_done_d = 1'b0;
    case (state_q)
      IDLE: begin
        if (pop) begin
          work_d  = fifo_q[rd_ptr_q];
          state_d = OP;
        end
      end
      OP: begin
        sel_d   = code_of(low_idx(work_q));
        en_op_d = 1'b1;
        state_d = OUT;
      end
      OUT: begin
        en_out_d = 1'b1;
        work_d   = work_q & (work_q - MASK_W'(1));
        if (work_d == '0) begin
          mask_done_d = 1'b1;
          state_d     = IDLE;
        end else begin
          state_d = OP;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State and output registers, synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      fifo_q      <= '0;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      cnt_q       <= '0;
      work_q      <= '0;
      sel_q       <= '0;
      en_op_q     <= 1'b0;
      en_out_q    <= 1'b0;
      mask_done_q <= 1'b0;
      err_zero_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      fifo_q      <= fifo_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      cnt_q       <= cnt_d;
      work_q      <= work_d;
      sel_q       <= sel_d;
      en_op_q     <= en_op_d;
      en_out_q    <= en_out_d;
      mask_done_q <= mask_done_d;
      err_zero_q  <= err_zero_d;
    end
  end

  assign sel       = sel_q;
  assign en_op     = en_op_q;
  assign en_out    = en_out_q;
  assign mask_done = mask_done_q;
  assign err_zero  = err_zero_q;

`ifdef WSEQ_STAT_CNT_EN
  logic [15:0] wr_count_q, wr_count_d;

  // Saturating count of out phases seen on the bus.
  always_comb begin
    wr_count_d = wr_count_q;
    if (en_out_q && (wr_count_q != 16'hFFFF)) wr_count_d = wr_count_q + 16'd1;
  end

  // Counter register.
  always_ff @(posedge clk) begin
    if (!rst_n) wr_count_q <= '0;
    else        wr_count_q <= wr_count_d;
  end

  assign wr_count = wr_count_q;
`endif

endmodule
